// File: rtl/sequence_controller.sv
// ============================================================================
// Module      : sequence_controller
// Description : Eight-phase VeriRISC instruction sequencer that decodes the
//               phase, opcode and zero flag into datapath control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_controller #(
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic [2:0]       phase,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             ld_ac,
    output logic             wr,
    output logic             data_e,
    output logic             halt
);

    localparam logic [2:0] c_inst_addr  = 3'd0;
    localparam logic [2:0] c_inst_fetch = 3'd1;
    localparam logic [2:0] c_inst_load  = 3'd2;
    localparam logic [2:0] c_idle       = 3'd3;
    localparam logic [2:0] c_op_addr    = 3'd4;
    localparam logic [2:0] c_op_fetch   = 3'd5;
    localparam logic [2:0] c_alu_op     = 3'd6;
    localparam logic [2:0] c_store      = 3'd7;

    localparam logic [2:0] c_hlt = 3'd0;
    localparam logic [2:0] c_skz = 3'd1;
    localparam logic [2:0] c_add = 3'd2;
    localparam logic [2:0] c_and = 3'd3;
    localparam logic [2:0] c_xor = 3'd4;
    localparam logic [2:0] c_lda = 3'd5;
    localparam logic [2:0] c_sto = 3'd6;
    localparam logic [2:0] c_jmp = 3'd7;

    generate
        if (OPC_W != 3) begin : g_bad_opc_w
            $error("sequence_controller: OPC_W must be 3");
        end
    endgenerate

    logic [2:0] r_phase;
    logic       r_halt;
    logic [2:0] w_op;
    logic       w_aluop;

    assign w_op    = opcode[2:0];
    assign w_aluop = (w_op == c_add) || (w_op == c_and) ||
                     (w_op == c_xor) || (w_op == c_lda);

    // A HLT decoded in OP_ADDR freezes the counter on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= c_inst_addr;
            r_halt  <= 1'b0;
        end else if (!r_halt) begin
            if ((r_phase == c_op_addr) && (w_op == c_hlt)) begin
                r_halt <= 1'b1;
            end else begin
                r_phase <= r_phase + 3'd1;
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (!r_halt) begin
            case (r_phase)
                c_inst_addr: begin
                    sel = 1'b1;
                end
                c_inst_fetch: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                c_inst_load, c_idle: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                c_op_addr: begin
                    inc_pc = 1'b1;
                end
                c_op_fetch: begin
                    rd = w_aluop;
                end
                c_alu_op: begin
                    rd     = w_aluop;
                    inc_pc = (w_op == c_skz) && zero;
                    ld_pc  = (w_op == c_jmp);
                    data_e = (w_op == c_sto);
                end
                c_store: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (w_op == c_jmp);
                    wr     = (w_op == c_sto);
                    data_e = (w_op == c_sto);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = r_phase;
    assign halt  = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_sequence_controller.sv
// ============================================================================
// Module      : tb_sequence_controller
// Description : Directed + randomized bench for sequence_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase = 0;
    bit m_halt  = 1'b0;

    sequence_controller #(.OPC_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e}
    function automatic logic [7:0] model_strobes(int p, int op, bit z, bit h);
        bit alu;
        bit is_exec;
        if (h) return 8'h00;
        alu     = (op >= 2) && (op <= 5);
        is_exec = (p == 6) || (p == 7);
        return {
            p <= 3,
            ((p >= 1) && (p <= 3)) || ((p >= 5) && alu),
            (p == 2) || (p == 3),
            (p == 4) || ((p == 6) && (op == 1) && z),
            is_exec && (op == 7),
            (p == 7) && alu,
            (p == 7) && (op == 6),
            is_exec && (op == 6)
        };
    endfunction

    task automatic check_outputs(string tag);
        logic [7:0] exp_s;
        logic [7:0] obs_s;
        exp_s = model_strobes(m_phase, int'(opcode), zero, m_halt);
        obs_s = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
        n_checks++;
        assert (phase === 3'(m_phase)) else begin
            n_fail++;
            $error("FAIL %s phase: observed %0d expected %0d", tag, phase, m_phase);
        end
        n_checks++;
        assert (halt === m_halt) else begin
            n_fail++;
            $error("FAIL %s halt: observed %0b expected %0b", tag, halt, m_halt);
        end
        n_checks++;
        assert (obs_s === exp_s) else begin
            n_fail++;
            $error("FAIL %s strobes(sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e) phase %0d op %0d: observed %b expected %b",
                   tag, m_phase, opcode, obs_s, exp_s);
        end
    endtask

    // One clock edge; the model advances using the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_halt  = 1'b0;
        end else if (!m_halt) begin
            if ((m_phase == 4) && (opcode == 3'd0)) m_halt = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
        #2;
    endtask

    task automatic step(string tag);
        #1;
        check_outputs(tag);
        tick();
    endtask

    // Full 8-phase instruction; zmode 0/1 forces zero, 2 randomizes it per cycle.
    task automatic run_instr(logic [2:0] op, int zmode, string tag);
        opcode = op;
        for (int i = 0; i < 8; i++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            step(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        #2;
        step("reset0");
        step("reset1");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("count");

        run_instr(3'd2, 2, "add");
        run_instr(3'd6, 2, "sto");
        run_instr(3'd7, 2, "jmp");
        run_instr(3'd1, 1, "skz_z1");
        run_instr(3'd1, 0, "skz_z0");

        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom_range(1, 7)), 2, "random");
        end

        opcode = 3'd0;
        for (int i = 0; i < 16; i++) begin
            zero = 1'($urandom_range(0, 1));
            step("hlt");
        end

        rst = 1'b1;
        step("hlt_rst");
        rst = 1'b0;
        step("after_hlt_rst");
        for (int i = 0; i < 7; i++) step("after_hlt_rst");

        opcode = 3'd2;
        for (int i = 0; i < 6; i++) step("add_pre_rst");
        rst = 1'b1;
        step("add_rst_ph6");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("add_post_rst");

        for (int n = 0; n < 10; n++) begin
            run_instr(3'($urandom_range(0, 7)), 2, "random_tail");
        end
        rst = 1'b1;
        step("final_rst");
        rst = 1'b0;
        step("final_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
